// File: rtl/imm_ext_stage.sv
// imm_ext_stage: registered immediate extension with a 2-entry skid buffer
// between decode and execute.
module imm_ext_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  Immediate,
    input  logic [2:0]       ExtMode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] ImExt,
    output logic [1:0]       occupancy,
    output logic             mode_err
);
    logic [OUT_W-1:0] r_main, r_skid;
    logic             r_main_v, r_skid_v, r_err;
    logic [OUT_W-1:0] w_zext, w_sext, w_upper, w_shl, w_ones, w_ext;
    logic             w_acc, w_xfer;

    assign w_zext  = {{(OUT_W-IN_W){1'b0}}, Immediate};
    assign w_sext  = {{(OUT_W-IN_W){Immediate[IN_W-1]}}, Immediate};
    assign w_upper = {Immediate, {(OUT_W-IN_W){1'b0}}};
    assign w_shl   = w_sext << 2;
    assign w_ones  = {{(OUT_W-IN_W){1'b1}}, Immediate};
    // illegal modes fall through to zero-extension
    assign w_ext   = ExtMode == 3'd1 ? w_sext  :
                     ExtMode == 3'd2 ? w_upper :
                     ExtMode == 3'd3 ? w_shl   :
                     ExtMode == 3'd4 ? w_ones  : w_zext;

    assign in_ready  = !r_skid_v && !Reset;
    assign w_acc     = in_valid && in_ready;
    assign w_xfer    = r_main_v && out_ready;
    assign out_valid = r_main_v;
    assign ImExt     = r_main;
    assign occupancy = {1'b0, r_main_v} + {1'b0, r_skid_v};
    assign mode_err  = r_err;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_main   <= '0;
            r_skid   <= '0;
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (r_skid_v) begin
                if (w_xfer) begin
                    r_main   <= r_skid;
                    r_skid_v <= 1'b0;
                end
            end else if (w_acc) begin
                if (!r_main_v || w_xfer) begin
                    r_main   <= w_ext;
                    r_main_v <= 1'b1;
                end else begin
                    r_skid   <= w_ext;
                    r_skid_v <= 1'b1;
                end
            end else if (w_xfer) begin
                r_main_v <= 1'b0;
            end
            if (w_acc && ExtMode > 3'd4)
                r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage: directed-vector bench for imm_ext_stage (IN_W=16, OUT_W=32).
module tb_imm_ext_stage;
    logic        CLK = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Immediate;
    logic [2:0]  ExtMode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ImExt;
    logic [1:0]  occupancy;
    logic        mode_err;
    int          n_cmp = 0;
    int          n_err = 0;

    imm_ext_stage #(.IN_W(16), .OUT_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .Immediate(Immediate), .ExtMode(ExtMode), .out_valid(out_valid),
        .out_ready(out_ready), .ImExt(ImExt), .occupancy(occupancy), .mode_err(mode_err)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; in_valid = 1'b1; Immediate = 16'h5555; ExtMode = 3'd0; out_ready = 1'b0;
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (ImExt !== 32'h0) begin n_err++; $display("FAIL rst_imext: got %h want 00000000", ImExt); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
        n_cmp++; if (mode_err !== 1'b0) begin n_err++; $display("FAIL rst_mode_err: got %b want 0", mode_err); end
        Reset = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_ext_modes();
        logic [15:0] imm [6] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h0001, 16'h8001};
        logic [2:0]  md  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3};
        logic [31:0] exp [6] = '{32'h00008001, 32'hFFFF8001, 32'h12340000, 32'hFFFFFFFC, 32'hFFFF0001, 32'hFFFE0004};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; Immediate = imm[i]; ExtMode = md[i];
            step();
            n_cmp++; if (out_valid !== 1'b1 || ImExt !== exp[i]) begin n_err++; $display("FAIL ext_mode%0d: got v=%b %h want v=1 %h", md[i], out_valid, ImExt, exp[i]); end
            n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL ext_occ%0d: got %0d want 1", i, occupancy); end
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_err++; $display("FAIL ext_drain: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0; in_valid = 1'b1; ExtMode = 3'd0; Immediate = 16'h0001;
        step();
        n_cmp++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin n_err++; $display("FAIL stall_a: got occ=%0d rdy=%b want occ=1 rdy=1", occupancy, in_ready); end
        Immediate = 16'h0002;
        step();
        n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin n_err++; $display("FAIL stall_b: got occ=%0d rdy=%b want occ=2 rdy=0", occupancy, in_ready); end
        Immediate = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1 || ImExt !== 32'h1 || occupancy !== 2'd2 || in_ready !== 1'b0) begin n_err++; $display("FAIL stall_hold%0d: got v=%b %h occ=%0d rdy=%b want v=1 00000001 occ=2 rdy=0", i, out_valid, ImExt, occupancy, in_ready); end
        end
        out_ready = 1'b1;
        step();
        n_cmp++; if (ImExt !== 32'h2 || occupancy !== 2'd1 || in_ready !== 1'b1) begin n_err++; $display("FAIL stall_out_b: got %h occ=%0d rdy=%b want 00000002 occ=1 rdy=1", ImExt, occupancy, in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || ImExt !== 32'h3 || occupancy !== 2'd1) begin n_err++; $display("FAIL stall_out_c: got v=%b %h occ=%0d want v=1 00000003 occ=1", out_valid, ImExt, occupancy); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_err++; $display("FAIL stall_drain: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1; ExtMode = 3'd0;
        for (int i = 0; i < 8; i++) begin
            Immediate = 16'h0010 + 16'(i);
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
            step();
            n_cmp++; if (out_valid !== 1'b1 || ImExt !== 32'h10 + 32'(i)) begin n_err++; $display("FAIL b2b_data%0d: got v=%b %h want v=1 %h", i, out_valid, ImExt, 32'h10 + 32'(i)); end
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_mode_err();
        out_ready = 1'b1; in_valid = 1'b1; ExtMode = 3'd6; Immediate = 16'h8000;
        step();
        n_cmp++; if (ImExt !== 32'h00008000 || mode_err !== 1'b1) begin n_err++; $display("FAIL err_set: got %h err=%b want 00008000 err=1", ImExt, mode_err); end
        ExtMode = 3'd1; Immediate = 16'h0001;
        step();
        n_cmp++; if (ImExt !== 32'h1 || mode_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %h err=%b want 00000001 err=1", ImExt, mode_err); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (mode_err !== 1'b1) begin n_err++; $display("FAIL err_hold: got %b want 1", mode_err); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; ExtMode = 3'd0; Immediate = 16'h00AA;
        step();
        Immediate = 16'h00BB;
        step();
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL mid_fill: got %0d want 2", occupancy); end
        Reset = 1'b1; Immediate = 16'h00CC; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
        step();
        Reset = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || ImExt !== 32'h0 || in_ready !== 1'b1 || mode_err !== 1'b0) begin n_err++; $display("FAIL mid_after: got v=%b occ=%0d %h rdy=%b err=%b want v=0 occ=0 00000000 rdy=1 err=0", out_valid, occupancy, ImExt, in_ready, mode_err); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_err++; $display("FAIL mid_stale%0d: got v=%b occ=%0d want v=0 occ=0", i, out_valid, occupancy); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; in_valid = 1'b0; Immediate = '0; ExtMode = '0; out_ready = 1'b0;
        test_reset();
        test_ext_modes();
        test_stall();
        test_back_to_back();
        test_mode_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
